// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - conditional-execution unit: NZCV status register and condition gating
//
// Holds the architectural NZCV flags, loads them from the ALU under decoder
// control, and evaluates the instruction condition field against the stored
// flags. A failed condition suppresses every architectural side effect,
// including the flag update itself.
//
// Ports:
//   clk       in   1  core clock, rising edge
//   reset     in   1  asynchronous active-low; clears the flags
//   Cond      in   4  instruction condition field [31:28]
//   ALUFlags  in   4  {N,Z,C,V} from the ALU
//   FlagW     in   2  [1] update N,Z ; [0] update C,V
//   PCS       in   1  decoder PC-write request
//   RegW      in   1  decoder register-write request
//   MemW      in   1  decoder memory-write request
//   NoWrite   in   1  compare-class op, result discarded
//   PCSrc     out  1  PCS gated by the condition
//   RegWrite  out  1  RegW gated by the condition and NoWrite
//   MemWrite  out  1  MemW gated by the condition
//   CondEx    out  1  condition passes against the registered flags
//   Flags     out  4  registered {N,Z,C,V}

module cond_logic (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Two independently enabled fields of the status register
    logic [1:0] nz_q, nz_d;
    logic [1:0] cv_q, cv_d;

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_ex;

    assign flag_n = nz_q[1];
    assign flag_z = nz_q[0];
    assign flag_c = cv_q[1];
    assign flag_v = cv_q[0];

    // Condition decode uses only the registered flags, so a flag-setting
    // conditional instruction is judged against the state before it.
    always_comb begin
        cond_ex = 1'b0;
        unique case (Cond)
            COND_EQ: cond_ex = flag_z;
            COND_NE: cond_ex = ~flag_z;
            COND_CS: cond_ex = flag_c;
            COND_CC: cond_ex = ~flag_c;
            COND_MI: cond_ex = flag_n;
            COND_PL: cond_ex = ~flag_n;
            COND_VS: cond_ex = flag_v;
            COND_VC: cond_ex = ~flag_v;
            COND_HI: cond_ex = flag_c & ~flag_z;
            COND_LS: cond_ex = ~flag_c | flag_z;
            COND_GE: cond_ex = (flag_n == flag_v);
            COND_LT: cond_ex = (flag_n != flag_v);
            COND_GT: cond_ex = ~flag_z & (flag_n == flag_v);
            COND_LE: cond_ex = flag_z | (flag_n != flag_v);
            COND_AL: cond_ex = 1'b1;
            // 1111 is reserved and treated as never-execute
            default: cond_ex = 1'b0;
        endcase
    end

    // Flag loads are gated by the condition so a skipped instruction
    // leaves the status register untouched.
    always_comb begin
        nz_d = nz_q;
        cv_d = cv_q;
        if (FlagW[1] && cond_ex) begin
            nz_d = ALUFlags[3:2];
        end
        if (FlagW[0] && cond_ex) begin
            cv_d = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nz_q <= 2'b00;
            cv_q <= 2'b00;
        end else begin
            nz_q <= nz_d;
            cv_q <= cv_d;
        end
    end

    assign CondEx   = cond_ex;
    assign PCSrc    = PCS & cond_ex;
    // Compare-class ops still set flags but never write a register
    assign RegWrite = RegW & cond_ex & ~NoWrite;
    assign MemWrite = MemW & cond_ex;
    assign Flags    = {nz_q, cv_q};

endmodule

// File: doc/cond_logic.md
# cond_logic

Conditional-execution unit for the single-cycle ARM core: the consumer side of the `alu` flag interface. It holds the architectural NZCV status register, loads it from `ALUFlags` under decoder control, and evaluates the instruction's 4-bit condition field against the stored flags. The result gates the decoder's write enables, so a failed condition suppresses every architectural side effect. It sits between the decoder/ALU and the register file, data memory and PC mux.

## Interface
- No parameters; all widths fixed by the ISA.
- `clk` input 1: core clock; rising-edge active.
- `reset` input 1: asynchronous, active-low; clears the status register.
- `Cond` input 4: instruction bits [31:28].
- `ALUFlags` input 4: {N,Z,C,V} from `alu`, bit 3 = N, bit 0 = V.
- `FlagW` input 2: bit 1 requests an N,Z update; bit 0 requests a C,V update.
- `PCS` input 1: decoder PC-write request (branch, or write to R15).
- `RegW` input 1: decoder register-write request.
- `MemW` input 1: decoder memory-write request.
- `NoWrite` input 1: decoder marks a compare-class op (CMP/CMN/TST/TEQ) whose result is discarded.
- `PCSrc` output 1: `PCS & CondEx`.
- `RegWrite` output 1: `RegW & CondEx & ~NoWrite`.
- `MemWrite` output 1: `MemW & CondEx`.
- `CondEx` output 1: the condition passes against the current flags.
- `Flags` output 4: current registered {N,Z,C,V}.

## Operation
- Status register: two independently enabled 2-bit fields, NZ = Flags[3:2] and CV = Flags[1:0].
- NZ loads `ALUFlags[3:2]` at a clock edge when `FlagW[1] & CondEx`.
- CV loads `ALUFlags[1:0]` at a clock edge when `FlagW[0] & CondEx`.
- A field whose enable is low holds its value.
- CondEx is computed from the registered `Flags` only, never from `ALUFlags`.

Condition decode (N, Z, C, V are the registered flags):
- 0000 EQ: Z.
- 0001 NE: ~Z.
- 0010 CS/HS: C.
- 0011 CC/LO: ~C.
- 0100 MI: N.
- 0101 PL: ~N.
- 0110 VS: V.
- 0111 VC: ~V.
- 1000 HI: C & ~Z.
- 1001 LS: ~C | Z.
- 1010 GE: N == V.
- 1011 LT: N != V.
- 1100 GT: ~Z & (N == V).
- 1101 LE: Z | (N != V).
- 1110 AL: 1.
- 1111: reserved; CondEx = 0. The instruction is treated as never-execute: no writes and no flag update.

Other rules:
- All outputs except `Flags` are purely combinational from the current inputs and registered flags. There are no X outputs for any input combination.
- With `NoWrite=1` the flags may still update (CMP behaviour), but `RegWrite` is forced to 0.

## Timing
- Reset asserted (`reset=0`), asynchronously: `Flags=4'b0000` immediately, independent of `clk`.
- Outputs with flags 0000: `CondEx` follows `Cond` (for example EQ=0, NE=1, AL=1, GE=1). `PCSrc`, `RegWrite` and `MemWrite` follow the gating equations.
- Reset deassertion: the first flag load can occur at the first rising edge after `reset` returns high.
- Reset asserted mid-cycle, including in the same cycle as an enabled load: reset wins, and `Flags` reads 0000 until release.
- Latency:
  - Decision: zero cycles; CondEx and the gated enables are valid in the same cycle as `Cond` and the flags.
  - Flag update: one cycle; an update becomes visible on `Flags` and to CondEx for the next instruction.
- Flag-setting conditional instruction: its own CondEx uses the old flags. A CMPEQ that fails leaves the flags unchanged.
- `FlagW=2'b10` (logical ops with S): C and V are preserved exactly.

## Test plan
- **Reset:** drive `reset=0` mid-cycle after flags were loaded as 1111 → `Flags=0000` with no clock edge; then Cond=0000 (EQ) → `CondEx=0`, and Cond=1110 → `CondEx=1`.
- **CMP 7,5:** ALUFlags=0010, FlagW=11, Cond=1110, NoWrite=1, RegW=1 → `RegWrite=0` this cycle; after the edge, `Flags=0010`. Next cycle: Cond=0000 (BEQ) with PCS=1 → `PCSrc=0`; Cond=0001 (BNE) → `PCSrc=1`; Cond=1000 (HI) → `CondEx=1`.
- **CMP 5,7:** ALUFlags=1000, FlagW=11 → `Flags=1000`. Then LT → 1, GE → 0, LE → 1, GT → 0, LO → 1.
- **Partial update:** Flags=1111; apply ALUFlags=0100 with FlagW=10 and Cond=AL → `Flags=0111`. Then ALUFlags=0000 with FlagW=01 → `Flags=0100`.
- **Failed condition blocks effects:** Flags=0000; Cond=0000 with FlagW=11, ALUFlags=1111, RegW=MemW=PCS=1 → `CondEx=0`, all three gated enables 0, and `Flags` stays 0000 after the edge.
- **Full sweep and reserved code:** iterate all 16 flag values × 16 Cond values against a reference model → exact match. Cond=1111 gives `CondEx=0` for all flags.
